// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared types, constants and helpers for the router output
// arbiter family.
//   policy_e       - arbitration policy (sticky / strict round-robin)
//   PORT_*         - port index map for the 5-port mesh router
//   onehot_to_idx  - one-hot (or zero) vector to binary index
package arbiter_pkg;

    typedef enum logic {
        POL_STICKY = 1'b0,
        POL_RR     = 1'b1
    } policy_e;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    // Widest port count the helpers below handle.
    localparam int MAX_PORTS = 32;

    // OR-reduces the indices of all set bits: exact for one-hot, 0 for zero.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational cyclic first-set search.
//   req        in  NUM_PORTS  request vector
//   start_idx  in  IDX_W      index searched first (must be < NUM_PORTS)
//   onehot_out out NUM_PORTS  first set req bit at or after start_idx
//                             (wrapping), zero when req is zero
module rr_pick #(
    parameter int  NUM_PORTS = 5,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start_idx,
    output logic [NUM_PORTS-1:0] onehot_out
);

    logic [NUM_PORTS-1:0] rot;
    logic [NUM_PORTS-1:0] rot_oh;

    // Rotate req right so start_idx lands on bit 0; the doubled copy
    // supplies the wrapped-around bits.
    assign rot = NUM_PORTS'({req, req} >> start_idx);

    // Isolate the lowest set bit (two's-complement trick).
    assign rot_oh = rot & (~rot + NUM_PORTS'(1));

    // Rotate back left; the upper half of the doubled word holds the result.
    assign onehot_out = NUM_PORTS'(({rot_oh, rot_oh} << start_idx) >> NUM_PORTS);

endmodule

// File: rtl/arbiter_rr_param.sv
// arbiter_rr_param: N-port output-channel arbiter with RTS/DCTS handshake.
//   clk        in  1          clock
//   rst        in  1          asynchronous active-low reset
//   req        in  NUM_PORTS  per-port request
//   tail       in  NUM_PORTS  per-port tail flag (only the owner's is used)
//   dcts       in  1          downstream clear-to-send
//   grant      out NUM_PORTS  one-hot transfer strobe (owner & rts & dcts)
//   xbar_sel   out NUM_PORTS  one-hot crossbar select (owner), 0 when idle
//   owner_idx  out IDX_W      binary owner index, 0 when idle
//   busy       out 1          an owner is selected
//   rts        out 1          registered request-to-send
// Supports 2..32 ports.
module arbiter_rr_param #(
    parameter int NUM_PORTS = 5,
    parameter int POLICY    = 0,
    parameter int PKT_LOCK  = 0,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 dcts,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic [IDX_W-1:0]     owner_idx,
    output logic                 busy,
    output logic                 rts
);

    import arbiter_pkg::*;

    logic [NUM_PORTS-1:0] owner;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] owner_nxt;
    logic [IDX_W-1:0]     last_ptr;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     start_idx;
    logic                 transfer;
    logic                 locked;
    logic                 hold;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_PORTS - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign busy     = |owner;
    assign transfer = rts & dcts;
    assign cur_idx  = IDX_W'(onehot_to_idx(MAX_PORTS'(owner)));
    assign pick_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(pick)));

    // Packet lock: the owner keeps the channel until its tail flit moves.
    // Dropping req mid-packet releases the lock so a bad source can't hang us.
    assign locked = (PKT_LOCK != 0) & busy & (|(req & owner))
                  & ~(transfer & (|(tail & owner)));

    // A pending RTS waiting on the downstream must not change hands.
    assign hold = (rts & ~dcts) | locked;

    always_comb begin
        start_idx = cur_idx;
        if (!busy)
            start_idx = idx_inc(last_ptr);
        else if (POLICY == int'(POL_RR) && transfer)
            start_idx = idx_inc(cur_idx);   // owner searched last
    end

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req        (req),
        .start_idx  (start_idx),
        .onehot_out (pick)
    );

    assign owner_nxt = hold ? owner : pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= '0;
            rts      <= 1'b0;
            last_ptr <= IDX_W'(NUM_PORTS - 1);
        end else begin
            owner <= owner_nxt;
            // Based on the current owner; drops for one cycle after each
            // transfer, which gives the 2-cycle flit cadence.
            rts   <= busy & ~transfer;
            if (!hold && |pick) last_ptr <= pick_idx;
        end
    end

    assign grant     = owner & {NUM_PORTS{transfer}};
    assign xbar_sel  = owner;
    assign owner_idx = cur_idx;

    a_owner_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(owner));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Bench for arbiter_rr_param: three instances share clk/rst.
//   A: 5 ports, sticky, no lock
//   B: 5 ports, round-robin, packet lock
//   C: 8 ports, sticky, no lock
// Expected values are queued with a selector naming the observed signal,
// then drained at the falling edge after the relevant rising edge.
module tb_arbiter_rr_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [4:0] a_req, a_tail, a_grant, a_xbar;
    logic       a_dcts, a_busy, a_rts;
    logic [2:0] a_idx;
    logic [4:0] b_req, b_tail, b_grant, b_xbar;
    logic       b_dcts, b_busy, b_rts;
    logic [2:0] b_idx;
    logic [7:0] c_req, c_tail, c_grant, c_xbar;
    logic       c_dcts, c_busy, c_rts;
    logic [2:0] c_idx;

    arbiter_rr_param #(.NUM_PORTS(5), .POLICY(0), .PKT_LOCK(0)) u_a (
        .clk(clk), .rst(rst), .req(a_req), .tail(a_tail), .dcts(a_dcts),
        .grant(a_grant), .xbar_sel(a_xbar), .owner_idx(a_idx), .busy(a_busy), .rts(a_rts));

    arbiter_rr_param #(.NUM_PORTS(5), .POLICY(1), .PKT_LOCK(1)) u_b (
        .clk(clk), .rst(rst), .req(b_req), .tail(b_tail), .dcts(b_dcts),
        .grant(b_grant), .xbar_sel(b_xbar), .owner_idx(b_idx), .busy(b_busy), .rts(b_rts));

    arbiter_rr_param #(.NUM_PORTS(8), .POLICY(0), .PKT_LOCK(0)) u_c (
        .clk(clk), .rst(rst), .req(c_req), .tail(c_tail), .dcts(c_dcts),
        .grant(c_grant), .xbar_sel(c_xbar), .owner_idx(c_idx), .busy(c_busy), .rts(c_rts));

    // Selector: base 0 = A, 10 = B, 20 = C; +0 grant, +1 xbar, +2 rts, +3 busy, +4 idx
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] get_obs(input int sel);
        case (sel)
            0:  return 32'(a_grant);
            1:  return 32'(a_xbar);
            2:  return 32'(a_rts);
            3:  return 32'(a_busy);
            4:  return 32'(a_idx);
            10: return 32'(b_grant);
            11: return 32'(b_xbar);
            12: return 32'(b_rts);
            13: return 32'(b_busy);
            14: return 32'(b_idx);
            20: return 32'(c_grant);
            21: return 32'(c_xbar);
            22: return 32'(c_rts);
            23: return 32'(c_busy);
            24: return 32'(c_idx);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // grant, xbar_sel, rts in one go
    task automatic exp3(input string tag, input int base, input logic [31:0] g,
                        input logic [31:0] x, input logic [31:0] r);
        push({tag, "_grant"}, base + 0, g);
        push({tag, "_xbar"},  base + 1, x);
        push({tag, "_rts"},   base + 2, r);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, get_obs(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic check_now();
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b0;
        a_req = '0; a_tail = '0; a_dcts = 1'b1;
        b_req = '0; b_tail = '0; b_dcts = 1'b1;
        c_req = '0; c_tail = '0; c_dcts = 1'b1;
        repeat (2) @(negedge clk);

        // ---- reset state
        exp3("rst_a", 0, 0, 0, 0);
        push("rst_a_busy", 3, 0);
        push("rst_a_idx", 4, 0);
        push("rst_b_busy", 13, 0);
        push("rst_c_busy", 23, 0);
        drain();
        rst = 1'b1;

        // ---- first request latency on A
        a_req = 5'b00010;
        exp3("lat1", 0, 0, 5'b00010, 0);
        push("lat1_idx", 4, 1);
        tick();
        exp3("lat2", 0, 5'b00010, 5'b00010, 1);
        tick();

        // ---- asynchronous reset mid-transfer
        rst = 1'b0;
        exp3("async", 0, 0, 0, 0);
        push("async_busy", 3, 0);
        check_now();
        #2 rst = 1'b1;
        exp3("rel1", 0, 0, 5'b00010, 0);
        tick();
        exp3("rel2", 0, 5'b00010, 5'b00010, 1);
        tick();

        // ---- sticky: N keeps the channel while requesting
        a_req = 5'b00110;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp3($sformatf("stk%0d", i), 0, 0, 5'b00010, 0);
            else            exp3($sformatf("stk%0d", i), 0, 5'b00010, 5'b00010, 1);
            tick();
        end
        a_req = 5'b00100;
        exp3("stk_mv", 0, 0, 5'b00100, 0);
        push("stk_mv_idx", 4, 2);
        tick();
        exp3("stk_e", 0, 5'b00100, 5'b00100, 1);
        tick();
        a_req = '0;
        exp3("stk_idle", 0, 0, 0, 0);
        push("stk_idle_busy", 3, 0);
        tick();

        // ---- backpressure on W, S arrives while held
        a_req = 5'b01000;
        a_dcts = 1'b0;
        exp3("bp_own", 0, 0, 5'b01000, 0);
        tick();
        exp3("bp_rts", 0, 0, 5'b01000, 1);
        tick();
        a_req = 5'b11000;
        for (int i = 0; i < 10; i++) begin
            exp3($sformatf("bp_hold%0d", i), 0, 0, 5'b01000, 1);
            tick();
        end
        a_dcts = 1'b1;
        exp3("bp_go", 0, 5'b01000, 5'b01000, 1);
        check_now();
        exp3("bp_gap", 0, 0, 5'b01000, 0);
        tick();
        exp3("bp_again", 0, 5'b01000, 5'b01000, 1);
        tick();
        a_req = '0;
        tick();

        // ---- strict round-robin on B (tail on every flit, so lock never holds)
        b_req = 5'b11111;
        b_tail = 5'b11111;
        for (int k = 1; k <= 12; k++) begin
            logic [4:0] oh;
            oh = 5'(1 << (((k - 1) / 2) % 5));
            if (k % 2 == 0) exp3($sformatf("rr%0d", k), 10, oh, oh, 1);
            else            exp3($sformatf("rr%0d", k), 10, 0, oh, 0);
            tick();
        end
        b_req = '0;
        push("rr_idle_busy", 13, 0);
        tick();

        // ---- packet lock on B: L sends 3 flits while N waits
        b_tail = '0;
        b_req = 5'b00001;
        exp3("lk1", 10, 0, 5'b00001, 0);
        tick();
        b_req = 5'b00011;
        exp3("lk2", 10, 5'b00001, 5'b00001, 1);
        tick();
        exp3("lk3", 10, 0, 5'b00001, 0);
        tick();
        exp3("lk4", 10, 5'b00001, 5'b00001, 1);
        tick();
        exp3("lk5", 10, 0, 5'b00001, 0);
        tick();
        b_tail = 5'b00001;
        exp3("lk6", 10, 5'b00001, 5'b00001, 1);
        tick();
        exp3("lk7", 10, 0, 5'b00010, 0);
        push("lk7_idx", 14, 1);
        tick();
        b_tail = '0;
        exp3("lk8", 10, 5'b00010, 5'b00010, 1);
        tick();
        // L starts a new packet, then abandons it
        b_req = 5'b00001;
        exp3("lk9", 10, 0, 5'b00001, 0);
        tick();
        b_req = 5'b00011;
        exp3("lk10", 10, 5'b00001, 5'b00001, 1);
        tick();
        b_tail = 5'b00010;   // tail on a non-owner must not release the lock
        exp3("lk11", 10, 0, 5'b00001, 0);
        tick();
        b_tail = '0;
        b_req = 5'b00010;
        exp3("lk12", 10, 5'b00010, 5'b00010, 1);
        push("lk12_idx", 14, 1);
        tick();
        b_req = '0;
        tick();

        // ---- idle fallback on C (8 ports)
        c_req = 8'h40;
        push("c_own6", 21, 8'h40);
        push("c_own6_idx", 24, 6);
        tick();
        c_req = '0;
        push("c_idle_busy", 23, 0);
        push("c_idle_rts", 22, 1);
        tick();
        push("c_idle_rts2", 22, 0);
        tick();
        c_req = 8'b0100_0001;
        push("c_fb_xbar", 21, 8'h01);
        push("c_fb_idx", 24, 0);
        push("c_fb_busy", 23, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_param.md
Name: arbiter_rr_param

Overview:
- Parametrised successor to the 5-port router output arbiter: N request ports competing for one output channel, generalised in port count.
- Keeps the RTS/DCTS flow-control handshake and one-hot crossbar select of the current arbiter.
- Adds selectable arbitration policy (sticky or strict round-robin) and optional packet locking (grant held until the tail flit).
- Sits in each router output port, between the input FIFOs' requests and the crossbar/downstream link.

Parameters:
- NUM_PORTS, 5, number of requesters (>=2); index 0 = Local, 1 = N, 2 = E, 3 = W, 4 = S when 5.
- POLICY, 0, 0 = sticky (owner keeps the channel while requesting), 1 = strict round-robin (owner rotates after every transfer).
- PKT_LOCK, 0, 1 = owner is held until a transfer with tail asserted.
- IDX_W, $clog2(NUM_PORTS), width of the owner index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req  in  NUM_PORTS  per-port request
- tail  in  NUM_PORTS  per-port "current flit is tail"; only sampled for the owner
- dcts  in  1  downstream clear-to-send
- grant  out  NUM_PORTS  one-hot transfer strobe: grant[i] = owner[i] & rts & dcts
- xbar_sel  out  NUM_PORTS  one-hot crossbar select = owner register; all-zero when idle
- owner_idx  out  IDX_W  binary index of owner; 0 when idle (qualify with busy)
- busy  out  1  owner register non-zero
- rts  out  1  registered request-to-send

Behaviour:
- Registers:
  - owner: one-hot, or all-zero for idle.
  - rts.
  - last_ptr: IDX_W bits, index of the most recent owner.
- Reset (rst=0, asynchronous): owner=0, rts=0, last_ptr=NUM_PORTS-1. Consequently grant=0, xbar_sel=0, busy=0, owner_idx=0 immediately; everything resumes on the first clk edge after rst rises.
- Signals:
  - transfer = rts & dcts.
  - locked = PKT_LOCK & busy & |(req & owner) & !(transfer & |(tail & owner)).
- Hold condition: (rts & !dcts) | locked → owner unchanged.
- Otherwise owner <= pick.
- pick:
  - Search cyclic from start index for the first set req bit; zero if req==0.
  - start = last_ptr+1 (mod NUM_PORTS) when idle.
  - start = owner index when POLICY=0 and busy (the owner wins if still requesting).
  - start = owner index + 1 when POLICY=1 and busy and transfer (the owner is searched last).
  - start = owner index when POLICY=1 and busy and !transfer.
- last_ptr <= index of the new owner whenever the new owner is non-zero.
- rts_next = busy & !(rts & dcts):
  - rts is evaluated on the current owner, not the next one.
  - rts drops for exactly one cycle after each transfer, then reasserts if still busy.
- Latency, from req rising at edge k while idle:
  - owner set at edge k+1.
  - rts=1 after edge k+2.
  - grant is valid in the cycle after edge k+2 if dcts=1.
  - Back-to-back transfers from one port: one flit every 2 cycles (matches the existing arbiter).
- Boundaries:
  - All req low while busy and not locked: owner returns to idle at the next decision point; rts clears the cycle after.
  - dcts held low: owner and rts=1 frozen indefinitely; no grant.
  - Owner drops req while PKT_LOCK: the lock releases and normal pick applies (protocol violation tolerated, no hang).
  - Tail on a non-owner port: ignored.
  - Multiple simultaneous new requests: the cyclic search order decides; no two grant bits are ever set.
  - owner is always one-hot or zero; an assertion must check this.

Decomposition:
- Shared package arbiter_pkg holds:
  - policy_e typedef (POL_STICKY=0, POL_RR=1).
  - Function onehot_to_idx.
  - Port-index constants PORT_L/N/E/W/S.
- One combinational sub-module, rr_pick (params NUM_PORTS; ports req, start_idx, onehot_out), implements the cyclic search via a double-width rotate and priority encode.

Test Plan:
- Reset/idle: rst=0 mid-transfer (owner=N, rts=1) → grant=0, xbar_sel=0, rts=0 asynchronously. After release, req[1]=1 → xbar_sel=5'b00010 after edge 1, rts=1 after edge 2.
- Sticky fairness (POLICY=0, dcts=1): req={N,E} held → owner stays N and grant[1] pulses every 2nd cycle. Drop req[1] → owner moves to E (xbar_sel=5'b00100).
- Round-robin (POLICY=1, dcts=1): req=5'b11111 held → grant order after reset is 0,1,2,3,4,0, one grant per 2-cycle slot.
- Backpressure: owner=W, rts=1, dcts=0 for 10 cycles while req[S] rises → owner and rts held, grant=0. dcts=1 → grant[3]=1 for one cycle, then rts=0 for one cycle.
- Packet lock (PKT_LOCK=1, POLICY=1): port L sends 3 flits with tail on the 3rd while req[N]=1 → 3 grants to L, then owner switches to N. Then L drops req mid-packet → lock releases at the next decision point.
- Idle fallback: NUM_PORTS=8, last owner 6, req=8'b01000001 arriving together from idle → owner 0 (search starts at 7).
